demux_sched_14: RTL and testbench
=================================

Name: demux_sched_14

Overview:
- Round-robin / directed scheduler that shares one input data stream among four downstream consumers.
- Drives the 2-bit select (s1,s0) and a one-hot strobe for a 1:4 demux fabric.
- Paces dispatch with per-channel credit counters, so no consumer receives more words than it has buffer space for.
- Sits between a single producer (valid/ready) and four credit-returning sinks.

Parameters:
- WIDTH, 8, data word width.
- CREDITS, 2, initial and maximum credits per channel (1..15); counters are 4 bits.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  producer has a word.
- in_data  input  WIDTH  producer word.
- in_dest  input  2  target channel; used only when mode=1.
- mode  input  1  0 = round-robin, 1 = directed; sampled with in_data.
- in_ready  output  1  scheduler accepts a word this cycle.
- credit_ret  input  4  per-channel one-cycle credit return pulse.
- sel  output  2  registered demux select; sel[1]=s1, sel[0]=s0.
- out_valid  output  4  registered one-hot dispatch strobe.
- out_data  output  WIDTH  registered dispatched word.
- stall  output  1  hold register full with no eligible channel.
- cr_err  output  1  sticky flag: credit return while that counter is already at CREDITS.

Behaviour:
- Reset values:
  - sel=0, out_valid=0, out_data=0, stall=0, cr_err=0.
  - Hold register empty (in_ready=1).
  - All credit counters = CREDITS.
  - Round-robin pointer = 0.
- Two states:
  - EMPTY: hold register invalid.
  - FULL: holds data, dest and mode.
- EMPTY: in_valid=1 captures in_data/in_dest/mode and moves to FULL. in_ready=1 in this state.
- FULL, eligible channel selection (combinational):
  - mode=0: first channel with credit>0 searching ptr, ptr+1, ... mod 4.
  - mode=1: channel in_dest only, if its credit>0.
- FULL with an eligible channel c: dispatch in this cycle t. At edge t+1:
  - sel=c, out_valid=1<<c, out_data=held word.
  - credit[c] decrements.
  - If mode=0, ptr=c+1 mod 4; ptr is unchanged by directed dispatches.
- Dispatch latency: a word accepted at edge e dispatches at the earliest in cycle e; out_valid appears at edge e+1.
- out_valid is high for exactly one cycle per word.
- When there is no dispatch, sel holds its last value and out_data holds its last value.
- in_ready = EMPTY or (FULL and dispatching this cycle).
  - Simultaneous dispatch plus new accept keeps FULL.
  - Sustained throughput is one word per cycle while credits last.
- FULL with no eligible channel: stall=1 (combinational), hold contents frozen, in_ready=0. A directed word never falls back to another channel.
- Credit return: credit_ret[i]=1 increments credit[i].
  - Return and dispatch on the same channel in the same cycle leave the count unchanged.
  - A return that would exceed CREDITS is dropped and sets cr_err=1. cr_err clears only on rst.
  - Multiple credit_ret bits may be high in one cycle; each is handled independently.
- Credits reaching 0 take effect in the very next decision cycle; there is no over-dispatch.
- Reset mid-operation: the held word is discarded, any pending out_valid is cleared, and credits and ptr are restored. rst has priority over all other events in that cycle.
- Arithmetic: ptr wraps 3→0; credit counters never underflow, because dispatch requires credit>0.

Test Plan:
- Reset then RR burst, CREDITS=2, mode=0:
  - Stimulus: drive words 0x10..0x17 back-to-back, no credit_ret.
  - Required: out_valid sequence 0001, 0010, 0100, 1000, 0001, 0010, 0100, 1000 on consecutive cycles; sel 0,1,2,3,0,1,2,3; then stall=1 and in_ready=0 with 0x18 held.
- Credit starvation skip:
  - Stimulus: exhaust ch1 (2 dispatches directed to 1), then send 4 words with mode=0, ptr=1.
  - Required: dispatch order 2,3,0,2. Ch1 is skipped.
- Directed blocking:
  - Stimulus: ch3 credit=0, send 0xA5 with mode=1, in_dest=3.
  - Required: stall=1 and no out_valid. Pulse credit_ret=1000 → 0xA5 appears on out_valid=1000, sel=3 one cycle after the pulse.
- Simultaneous return/dispatch:
  - Stimulus: ch0 credit=1; dispatch to ch0 in the same cycle as credit_ret[0]=1.
  - Required: ch0 credit stays 1. An immediate second directed word to ch0 dispatches without stall.
- Credit overflow:
  - Stimulus: at reset state, pulse credit_ret=0100.
  - Required: cr_err=1 and stays 1. Ch2 credit stays 2: only 2 dispatches to ch2 before stall.
- Reset mid-operation:
  - Stimulus: while FULL and stalled, assert rst for 1 cycle.
  - Required: next cycle in_ready=1, out_valid=0, stall=0, cr_err=0. The held word is never output, and the first subsequent mode=0 word goes to ch0.

Source files
------------

// File: rtl/demux_sched_14_if.sv
// Bus between producer, credit-returning sinks and demux_sched_14.
// master: producer/sink side; slave: scheduler side.
interface demux_sched_14_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_dest;
  logic             mode;
  logic             in_ready;
  logic [3:0]       credit_ret;
  logic [1:0]       sel;
  logic [3:0]       out_valid;
  logic [WIDTH-1:0] out_data;
  logic             stall;
  logic             cr_err;

  modport master (
    output in_valid, in_data, in_dest, mode,
    output credit_ret,
    input  in_ready, sel, out_valid, out_data,
    input  stall, cr_err
  );

  modport slave (
    input  in_valid, in_data, in_dest, mode,
    input  credit_ret,
    output in_ready, sel, out_valid, out_data,
    output stall, cr_err
  );
endinterface

// File: rtl/demux_sched_14.sv
// Credit-paced round-robin/directed scheduler for a 1:4 demux.
// Ports: clk, rst (sync, high), bus (slave: producer in, demux out).
module demux_sched_14 #(
  parameter int WIDTH   = 8,
  parameter int CREDITS = 2
) (
  input  logic           clk,
  input  logic           rst,
  demux_sched_14_if.slave bus
);
  localparam logic [3:0] CMAX = 4'(CREDITS);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t           state;
  logic [WIDTH-1:0] h_data;
  logic [1:0]       h_dest;
  logic             h_mode;
  logic [3:0]       credit [4];
  logic [1:0]       ptr;

  logic [1:0]       sel_r;
  logic [3:0]       ov_r;
  logic [WIDTH-1:0] od_r;
  logic             err_r;

  logic             elig;
  logic [1:0]       ch;
  logic [1:0]       idx;
  logic             disp;
  logic             accept;
  logic [3:0]       dec;

  // Pick the dispatch channel. The RR search runs from the
  // farthest offset down so the nearest one to ptr wins.
  always_comb begin
    elig = 1'b0;
    ch   = h_dest;
    idx  = ptr;
    if (h_mode) begin
      elig = (credit[h_dest] != 4'd0);
    end else begin
      for (int k = 3; k >= 0; k--) begin
        idx = ptr + 2'(k);
        if (credit[idx] != 4'd0) begin
          elig = 1'b1;
          ch   = idx;
        end
      end
    end
  end

  assign disp   = (state == FULL) && elig;
  assign accept = bus.in_valid && bus.in_ready;
  assign dec    = disp ? (4'b0001 << ch) : 4'b0000;

  assign bus.in_ready  = (state == EMPTY) || disp;
  assign bus.stall     = (state == FULL) && !elig;
  assign bus.sel       = sel_r;
  assign bus.out_valid = ov_r;
  assign bus.out_data  = od_r;
  assign bus.cr_err    = err_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= EMPTY;
      h_data <= '0;
      h_dest <= 2'd0;
      h_mode <= 1'b0;
      ptr    <= 2'd0;
      sel_r  <= 2'd0;
      ov_r   <= 4'd0;
      od_r   <= '0;
      err_r  <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        credit[i] <= CMAX;
      end
    end else begin
      ov_r <= 4'd0;
      if (disp) begin
        sel_r <= ch;
        ov_r  <= 4'b0001 << ch;
        od_r  <= h_data;
        if (!h_mode) begin
          ptr <= ch + 2'd1;
        end
      end

      if (accept) begin
        state  <= FULL;
        h_data <= bus.in_data;
        h_dest <= bus.in_dest;
        h_mode <= bus.mode;
      end else if (disp) begin
        state <= EMPTY;
      end

      // Return and dispatch on one channel cancel out.
      for (int i = 0; i < 4; i++) begin
        if (bus.credit_ret[i] && !dec[i]) begin
          if (credit[i] == CMAX) begin
            err_r <= 1'b1;
          end else begin
            credit[i] <= credit[i] + 4'd1;
          end
        end else if (dec[i] && !bus.credit_ret[i]) begin
          credit[i] <= credit[i] - 4'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_demux_sched_14.sv
// Directed bench for demux_sched_14.
// Table-driven vectors plus multi-cycle corner sequences.
module tb_demux_sched_14;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  demux_sched_14_if #(.WIDTH(8)) bus ();

  demux_sched_14 #(
    .WIDTH(8),
    .CREDITS(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errs   = 0;

  typedef struct {
    logic [3:0] ov;
    logic [7:0] d;
  } ev_t;
  ev_t log_q[$];

  always @(negedge clk) begin
    if (bus.out_valid != 4'd0) begin
      log_q.push_back('{bus.out_valid, bus.out_data});
    end
  end

  typedef struct {
    logic       rst;
    logic       v;
    logic [7:0] d;
    logic [1:0] dst;
    logic       m;
    logic [3:0] cr;
    logic [3:0] ov;
    logic [1:0] sel;
    logic [7:0] od;
    logic       rdy;
    logic       st;
    logic       ce;
  } vec_t;
  vec_t tbl[15];

  function automatic vec_t mk(
    input logic r, input logic v, input logic [7:0] d,
    input logic [3:0] ov, input logic [1:0] s,
    input logic [7:0] od, input logic rdy, input logic st
  );
    vec_t x;
    x.rst = r;  x.v = v;   x.d = d;  x.dst = 2'd0;
    x.m = 1'b0; x.cr = 4'd0;
    x.ov = ov;  x.sel = s; x.od = od;
    x.rdy = rdy; x.st = st; x.ce = 1'b0;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data = 8'd0;
    bus.in_dest = 2'd0;
    bus.mode = 1'b0;
    bus.credit_ret = 4'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input logic [1:0] dst,
                      input logic m);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data = d;
    bus.in_dest = dst;
    bus.mode = m;
    #1;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 50) begin
      errs++;
      checks++;
      $display("FAIL send_timeout: word %0h never accepted", d);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // RR burst 0x10..0x18, stall, reset mid-op, first word to ch0.
    tbl[0]  = mk(0, 1, 8'h10, 4'h0, 2'd0, 8'h00, 1, 0);
    tbl[1]  = mk(0, 1, 8'h11, 4'h0, 2'd0, 8'h00, 1, 0);
    tbl[2]  = mk(0, 1, 8'h12, 4'h1, 2'd0, 8'h10, 1, 0);
    tbl[3]  = mk(0, 1, 8'h13, 4'h2, 2'd1, 8'h11, 1, 0);
    tbl[4]  = mk(0, 1, 8'h14, 4'h4, 2'd2, 8'h12, 1, 0);
    tbl[5]  = mk(0, 1, 8'h15, 4'h8, 2'd3, 8'h13, 1, 0);
    tbl[6]  = mk(0, 1, 8'h16, 4'h1, 2'd0, 8'h14, 1, 0);
    tbl[7]  = mk(0, 1, 8'h17, 4'h2, 2'd1, 8'h15, 1, 0);
    tbl[8]  = mk(0, 1, 8'h18, 4'h4, 2'd2, 8'h16, 1, 0);
    tbl[9]  = mk(0, 0, 8'h00, 4'h8, 2'd3, 8'h17, 0, 1);
    tbl[10] = mk(0, 0, 8'h00, 4'h0, 2'd3, 8'h17, 0, 1);
    tbl[11] = mk(1, 0, 8'h00, 4'h0, 2'd3, 8'h17, 0, 1);
    tbl[12] = mk(0, 1, 8'h20, 4'h0, 2'd0, 8'h00, 1, 0);
    tbl[13] = mk(0, 0, 8'h00, 4'h0, 2'd0, 8'h00, 1, 0);
    tbl[14] = mk(0, 0, 8'h00, 4'h1, 2'd0, 8'h20, 1, 0);

    do_reset();
    #1;
    chk("reset_out_valid", bus.out_valid, 4'h0);
    chk("reset_in_ready", bus.in_ready, 1'b1);
    chk("reset_stall", bus.stall, 1'b0);
    chk("reset_cr_err", bus.cr_err, 1'b0);
    @(negedge clk);

    for (int i = 0; i < 15; i++) begin
      rst = tbl[i].rst;
      bus.in_valid = tbl[i].v;
      bus.in_data = tbl[i].d;
      bus.in_dest = tbl[i].dst;
      bus.mode = tbl[i].m;
      bus.credit_ret = tbl[i].cr;
      #1;
      chk($sformatf("v%0d_out_valid", i), bus.out_valid, tbl[i].ov);
      chk($sformatf("v%0d_sel", i), bus.sel, tbl[i].sel);
      chk($sformatf("v%0d_out_data", i), bus.out_data, tbl[i].od);
      chk($sformatf("v%0d_in_ready", i), bus.in_ready, tbl[i].rdy);
      chk($sformatf("v%0d_stall", i), bus.stall, tbl[i].st);
      chk($sformatf("v%0d_cr_err", i), bus.cr_err, tbl[i].ce);
      @(negedge clk);
    end
    rst = 1'b0;
    bus.in_valid = 1'b0;

    // Credit starvation skip: ch1 exhausted, RR from ptr=1.
    begin
      logic [3:0] exp_ov[7];
      exp_ov = '{4'h1, 4'h2, 4'h2, 4'h4, 4'h8, 4'h1, 4'h4};
      do_reset();
      log_q.delete();
      send(8'h40, 2'd0, 1'b0);
      send(8'h41, 2'd1, 1'b1);
      send(8'h42, 2'd1, 1'b1);
      for (int k = 0; k < 4; k++) send(8'(8'h43 + k), 2'd0, 1'b0);
      idle(3);
      #1;
      chk("starve_count", log_q.size(), 7);
      for (int k = 0; k < 7; k++) begin
        if (k < log_q.size()) begin
          chk($sformatf("starve_ov%0d", k), log_q[k].ov, exp_ov[k]);
          chk($sformatf("starve_d%0d", k), log_q[k].d, 8'(8'h40 + k));
        end
      end
    end

    // Directed blocking on ch3 until a credit comes back.
    do_reset();
    log_q.delete();
    send(8'h50, 2'd3, 1'b1);
    send(8'h51, 2'd3, 1'b1);
    send(8'hA5, 2'd3, 1'b1);
    idle(3);
    #1;
    chk("block_stall", bus.stall, 1'b1);
    chk("block_in_ready", bus.in_ready, 1'b0);
    chk("block_count", log_q.size(), 2);
    bus.credit_ret = 4'b1000;
    @(negedge clk);
    bus.credit_ret = 4'b0000;
    #1;
    chk("block_pulse_ov", bus.out_valid, 4'h0);
    chk("block_pulse_stall", bus.stall, 1'b0);
    @(negedge clk);
    #1;
    chk("block_rel_ov", bus.out_valid, 4'h8);
    chk("block_rel_sel", bus.sel, 2'd3);
    chk("block_rel_data", bus.out_data, 8'hA5);

    // Return and dispatch on ch0 in the same cycle.
    do_reset();
    log_q.delete();
    send(8'h60, 2'd0, 1'b0);
    idle(2);
    send(8'h61, 2'd0, 1'b1);
    bus.credit_ret = 4'b0001;
    @(negedge clk);
    bus.credit_ret = 4'b0000;
    send(8'h62, 2'd0, 1'b1);
    #1;
    chk("simul_second_stall", bus.stall, 1'b0);
    send(8'h63, 2'd0, 1'b1);
    #1;
    chk("simul_third_stall", bus.stall, 1'b1);
    idle(1);
    #1;
    chk("simul_count", log_q.size(), 3);
    if (log_q.size() == 3) begin
      chk("simul_ov2", log_q[2].ov, 4'h1);
      chk("simul_d2", log_q[2].d, 8'h62);
    end

    // Credit overflow is dropped and flagged.
    do_reset();
    log_q.delete();
    bus.credit_ret = 4'b0100;
    @(negedge clk);
    bus.credit_ret = 4'b0000;
    #1;
    chk("ovf_cr_err", bus.cr_err, 1'b1);
    send(8'h70, 2'd2, 1'b1);
    send(8'h71, 2'd2, 1'b1);
    send(8'h72, 2'd2, 1'b1);
    idle(3);
    #1;
    chk("ovf_count", log_q.size(), 2);
    chk("ovf_stall", bus.stall, 1'b1);
    chk("ovf_cr_err_sticky", bus.cr_err, 1'b1);
    do_reset();
    #1;
    chk("ovf_rst_cr_err", bus.cr_err, 1'b0);
    chk("ovf_rst_stall", bus.stall, 1'b0);
    chk("ovf_rst_in_ready", bus.in_ready, 1'b1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
